collision_scorer: RTL and testbench

COLLISION_SCORER -- requirements
Module: collision_scorer

---
 rtl/game_pkg.sv | 15 +
 rtl/collision_scorer_bcd_inc4.sv | 34 +++
 rtl/collision_scorer.sv | 132 +++++++++++++
 tb/tb_collision_scorer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the collision/score block of the runner game.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_e;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [15:0] SCORE_MAX_BCD       = 16'h9999;
    localparam int          GRACE_TICKS_DEFAULT = 2;

endpackage

// File: rtl/collision_scorer_bcd_inc4.sv
// bcd_inc4: combinational 4-digit BCD +1 with saturation at 9999.
module bcd_inc4
    import game_pkg::*;
(
    input  logic [15:0] value_i,
    output logic [15:0] value_o,
    output logic        sat_o
);

    bcd_digit_t digit;
    logic       carry;

    // Ripple a decimal carry from the least significant digit upward.
    always_comb begin
        value_o = value_i;
        sat_o   = (value_i == SCORE_MAX_BCD);
        carry   = 1'b1;
        digit   = '0;
        if (!sat_o) begin
            for (int i = 0; i < 4; i++) begin
                digit = value_i[4*i +: 4];
                if (carry) begin
                    if (digit == 4'd9) begin
                        value_o[4*i +: 4] = 4'd0;
                    end else begin
                        value_o[4*i +: 4] = digit + 4'd1;
                        carry             = 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/collision_scorer.sv
// collision_scorer: run/over FSM, collision detection and BCD score keeping.
// Define COLLISION_SCORER_HISCORE_EN to track the best score in hi_bcd.
module collision_scorer
    import game_pkg::*;
#(
    parameter int GRACE_TICKS = GRACE_TICKS_DEFAULT,
    parameter int OBST_W      = 2,
    parameter int RUN_W       = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              tick,
    input  logic [RUN_W-1:0]  runner_h,
    input  logic [OBST_W-1:0] obst_h,
    output logic              game_over,
    output logic              hit_pulse,
    output logic [15:0]       score_bcd,
    output logic [15:0]       hi_bcd
);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] RUN  = ST_RUN;
    localparam logic [1:0] OVER = ST_OVER;

    localparam int GRACE_W = (GRACE_TICKS > 0) ? $clog2(GRACE_TICKS + 1) : 1;
    localparam int CMP_W   = (OBST_W > RUN_W) ? OBST_W : RUN_W;

    logic [1:0]         state_q, state_d;
    logic [15:0]        score_q, score_d;
    logic [GRACE_W-1:0] grace_q, grace_d;
    logic               game_over_q, game_over_d;
    logic               hit_pulse_q, hit_pulse_d;

    logic [15:0] score_inc;
    logic        score_sat;
    logic        collide;
    logic        enter_over;

    bcd_inc4 u_bcd_inc4 (
        .value_i (score_q),
        .value_o (score_inc),
        .sat_o   (score_sat)
    );

    assign collide    = (obst_h != '0) && (CMP_W'(obst_h) > CMP_W'(runner_h));
    assign enter_over = (state_q == RUN) && (state_d == OVER);

    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        grace_d     = grace_q;
        game_over_d = game_over_q;
        hit_pulse_d = 1'b0;
        case (state_q)
            IDLE, OVER: begin
                // start takes priority; any tick in the same cycle is dropped
                if (start) begin
                    state_d     = RUN;
                    score_d     = '0;
                    grace_d     = GRACE_W'(GRACE_TICKS);
                    game_over_d = 1'b0;
                end
            end
            RUN: begin
                if (tick) begin
                    if (grace_q != '0) begin
                        grace_d = grace_q - 1'b1;
                        score_d = score_sat ? score_q : score_inc;
                    end else if (collide) begin
                        state_d     = OVER;
                        game_over_d = 1'b1;
                        hit_pulse_d = 1'b1;
                    end else begin
                        score_d = score_sat ? score_q : score_inc;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                game_over_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            score_q     <= '0;
            grace_q     <= '0;
            game_over_q <= 1'b0;
            hit_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            grace_q     <= grace_d;
            game_over_q <= game_over_d;
            hit_pulse_q <= hit_pulse_d;
        end
    end

`ifdef COLLISION_SCORER_HISCORE_EN
    logic [15:0] hi_q, hi_d;

    // Plain binary compare orders BCD values correctly.
    always_comb begin
        hi_d = hi_q;
        if (enter_over && (score_q > hi_q)) begin
            hi_d = score_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hi_q <= '0;
        end else begin
            hi_q <= hi_d;
        end
    end

    assign hi_bcd = hi_q;
`else
    logic unused_enter_over;
    assign unused_enter_over = enter_over;
    assign hi_bcd            = '0;
`endif

    assign game_over = game_over_q;
    assign hit_pulse = hit_pulse_q;
    assign score_bcd = score_q;

endmodule

// File: tb/tb_collision_scorer.sv
// Randomized and directed bench for collision_scorer against a decimal-integer game model.
module tb_collision_scorer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        tick = 1'b0;
    logic [4:0]  runner_h = '0;
    logic [1:0]  obst_h = '0;
    logic        game_over;
    logic        hit_pulse;
    logic [15:0] score_bcd;
    logic [15:0] hi_bcd;

    int checks = 0;
    int failures = 0;

    // Reference model: plain integers, 0=idle 1=run 2=over
    int m_state = 0;
    int m_score = 0;
    int m_hi = 0;
    int m_grace = 0;
    bit m_over = 0;
    bit m_hit = 0;

    localparam int GRACE = 2;
`ifdef COLLISION_SCORER_HISCORE_EN
    localparam bit HI_EN = 1'b1;
`else
    localparam bit HI_EN = 1'b0;
`endif

    collision_scorer dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .tick      (tick),
        .runner_h  (runner_h),
        .obst_h    (obst_h),
        .game_over (game_over),
        .hit_pulse (hit_pulse),
        .score_bcd (score_bcd),
        .hi_bcd    (hi_bcd)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        return 16'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10));
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    task automatic modelStep(input bit rn, input bit st, input bit tk, input int rh, input int oh);
        if (!rn) begin
            m_state = 0; m_score = 0; m_hi = 0; m_grace = 0; m_over = 0; m_hit = 0;
            return;
        end
        m_hit = 0;
        if (m_state != 1) begin
            if (st) begin
                m_state = 1; m_score = 0; m_grace = GRACE; m_over = 0;
            end
        end else if (tk) begin
            if (m_grace > 0) begin
                m_grace--;
                if (m_score < 9999) m_score++;
            end else if (oh > rh) begin
                m_state = 2; m_over = 1; m_hit = 1;
                if (HI_EN && m_score > m_hi) m_hi = m_score;
            end else if (m_score < 9999) begin
                m_score++;
            end
        end
    endtask

    task automatic applyStimulus(input bit rn, input bit st, input bit tk, input int rh, input int oh);
        resetn   = rn;
        start    = st;
        tick     = tk;
        runner_h = 5'(rh);
        obst_h   = 2'(oh);
        @(posedge clk);
        modelStep(rn, st, tk, rh, oh);
        #1;
        checkOutput("score", score_bcd, to_bcd(m_score));
        checkOutput("hi", hi_bcd, to_bcd(m_hi));
        checkOutput("game_over", 16'(game_over), 16'(m_over));
        checkOutput("hit_pulse", 16'(hit_pulse), 16'(m_hit));
    endtask

    task automatic runTicks(input int n, input int rh, input int oh);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 1, rh, oh);
    endtask

    task automatic crash();
        applyStimulus(1, 0, 1, 0, 3);
    endtask

    initial begin
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 3);
        checkOutput("reset_score", score_bcd, 16'h0000);
        checkOutput("reset_over", 16'(game_over), 16'h0000);

        // Five clean ticks after start
        applyStimulus(1, 1, 0, 0, 0);
        runTicks(5, 0, 0);
        checkOutput("five_ticks", score_bcd, 16'h0005);
        checkOutput("five_ticks_over", 16'(game_over), 16'h0000);

        // Grace ignores an obstacle, then a real hit on the third tick
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 3);
        checkOutput("grace_score", score_bcd, 16'h0001);
        applyStimulus(1, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 1, 2);
        checkOutput("hit_pulse_set", 16'(hit_pulse), 16'h0001);
        checkOutput("hit_score", score_bcd, 16'h0002);
        applyStimulus(1, 0, 0, 1, 2);
        checkOutput("hit_pulse_clear", 16'(hit_pulse), 16'h0000);
        checkOutput("hit_over", 16'(game_over), 16'h0001);

        // Ticks in OVER hold the score; start restarts
        runTicks(3, 0, 0);
        checkOutput("over_hold", score_bcd, 16'h0002);
        applyStimulus(1, 1, 1, 0, 0);
        checkOutput("restart_score", score_bcd, 16'h0000);
        checkOutput("restart_over", 16'(game_over), 16'h0000);

        // Equal heights are not a collision
        runTicks(GRACE, 0, 0);
        applyStimulus(1, 0, 1, 2, 2);
        checkOutput("equal_no_hit", 16'(game_over), 16'h0000);

        // Decimal carry 0099 -> 0100 and saturation at 9999
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        runTicks(99, 3, 3);
        checkOutput("carry_pre", score_bcd, 16'h0099);
        runTicks(1, 3, 3);
        checkOutput("carry_post", score_bcd, 16'h0100);
        runTicks(9899, 0, 0);
        checkOutput("sat_reach", score_bcd, 16'h9999);
        runTicks(2, 0, 0);
        checkOutput("sat_hold", score_bcd, 16'h9999);

        // High score: run of 12 then run of 7
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        runTicks(12, 0, 0);
        crash();
        applyStimulus(1, 1, 0, 0, 0);
        runTicks(7, 0, 0);
        crash();
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("hi_two_runs", hi_bcd, HI_EN ? 16'h0012 : 16'h0000);

        // Same-cycle start and tick from IDLE; then reset mid-run at 42
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 0);
        checkOutput("start_tick_score", score_bcd, 16'h0000);
        runTicks(42, 0, 0);
        checkOutput("pre_reset", score_bcd, 16'h0042);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("mid_reset_score", score_bcd, 16'h0000);
        checkOutput("mid_reset_hi", hi_bcd, 16'h0000);

        // Randomized play
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 199) != 0), ($urandom_range(0, 29) == 0),
                          $urandom_range(0, 1) == 1, int'($urandom_range(0, 4)),
                          int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
